// File: rtl/logic_reset_sequencer_pkg.sv
// Shared types and sizing helpers for the reset release sequencer.
package logic_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    STATE_HOLD,
    STATE_RELEASE,
    STATE_DONE
  } state_t;

  function automatic int unsigned counter_width(input int unsigned hold,
                                                input int unsigned delay);
    int unsigned longest;
    longest = (hold > delay) ? hold : delay;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/logic_reset_synchronizer_unit.sv
// Reset synchronizer: asserts asynchronously, releases after STAGES clock edges.
module logic_reset_synchronizer_unit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic areset_n,
  output logic rst_n
);

  logic [STAGES-1:0] sync;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[STAGES-2:0], 1'b1};
    end
  end

  assign rst_n = sync[STAGES-1];

endmodule

// File: rtl/logic_reset_sequencer.sv
// Releases OUTPUTS active-low resets in index order after a hold period, DELAY cycles apart.
module logic_reset_sequencer
  import logic_reset_sequencer_pkg::*;
#(
  parameter int unsigned STAGES  = 2,
  parameter int unsigned OUTPUTS = 4,
  parameter int unsigned HOLD    = 8,
  parameter int unsigned DELAY   = 16
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               soft_reset,
  output logic [OUTPUTS-1:0] resets_n,
  output logic               ready
);

  localparam int unsigned CNT_W = counter_width(HOLD, DELAY);
  localparam int unsigned IDX_W = $clog2(OUTPUTS + 1);
  localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] DELAY_TC = CNT_W'(DELAY - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUTS - 1);

  if (STAGES < 2) begin : g_drc_stages
    $error("logic_reset_sequencer: STAGES must be >= 2");
  end
  if (OUTPUTS < 1) begin : g_drc_outputs
    $error("logic_reset_sequencer: OUTPUTS must be >= 1");
  end
  if (HOLD < 1) begin : g_drc_hold
    $error("logic_reset_sequencer: HOLD must be >= 1");
  end
  if (DELAY < 1) begin : g_drc_delay
    $error("logic_reset_sequencer: DELAY must be >= 1");
  end

  logic               rst_n;
  state_t             state, state_next;
  logic [CNT_W-1:0]   count, count_next;
  logic [IDX_W-1:0]   idx, idx_next;
  logic [OUTPUTS-1:0] resets_next;
  logic               ready_next;

  logic_reset_synchronizer_unit #(
    .STAGES(STAGES)
  ) u_sync (
    .clk     (aclk),
    .areset_n(!areset),
    .rst_n   (rst_n)
  );

  always_comb begin
    state_next  = state;
    count_next  = count;
    idx_next    = idx;
    resets_next = resets_n;
    if (soft_reset) begin
      state_next  = STATE_HOLD;
      count_next  = '0;
      idx_next    = '0;
      resets_next = '0;
    end else begin
      unique case (state)
        STATE_HOLD: begin
          if (count == HOLD_TC) begin
            count_next     = '0;
            resets_next[0] = 1'b1;
            if (OUTPUTS == 1) begin
              state_next = STATE_DONE;
            end else begin
              state_next = STATE_RELEASE;
              idx_next   = IDX_W'(1);
            end
          end else begin
            count_next = count + 1'b1;
          end
        end
        STATE_RELEASE: begin
          if (count == DELAY_TC) begin
            count_next       = '0;
            resets_next[idx] = 1'b1;
            if (idx == LAST_IDX) begin
              state_next = STATE_DONE;
            end else begin
              idx_next = idx + 1'b1;
            end
          end else begin
            count_next = count + 1'b1;
          end
        end
        STATE_DONE: begin
        end
        default: begin
          state_next = STATE_HOLD;
        end
      endcase
    end
    // ready is registered alongside resets_n so it tracks &resets_n exactly
    ready_next = &resets_next;
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= STATE_HOLD;
      count    <= '0;
      idx      <= '0;
      resets_n <= '0;
      ready    <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      idx      <= idx_next;
      resets_n <= resets_next;
      ready    <= ready_next;
    end
  end

endmodule

// File: tb/tb_logic_reset_sequencer.sv
// Randomized scoreboard bench for logic_reset_sequencer against a release-time model.
module tb_logic_reset_sequencer;

  localparam int STAGES  = 2;
  localparam int OUTPUTS = 3;
  localparam int HOLD    = 3;
  localparam int DELAY   = 4;
  localparam int CYCLES  = 3000;

  typedef struct packed {
    logic [OUTPUTS-1:0] rn;
    logic               rdy;
  } exp_t;

  logic               aclk = 1'b0;
  logic               areset = 1'b1;
  logic               soft_reset = 1'b0;
  logic [OUTPUTS-1:0] resets_n;
  logic               ready;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Model state: edge count, synchronizer progress and the edge the current sequence counts from.
  int edge_n = 0;
  int sync_cnt = 0;
  int base = 0;

  always #5 aclk = ~aclk;

  logic_reset_sequencer #(
    .STAGES (STAGES),
    .OUTPUTS(OUTPUTS),
    .HOLD   (HOLD),
    .DELAY  (DELAY)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .soft_reset(soft_reset),
    .resets_n  (resets_n),
    .ready     (ready)
  );

  task automatic model_edge();
    edge_n++;
    if (areset) begin
      sync_cnt = 0;
    end else if (sync_cnt < STAGES) begin
      sync_cnt++;
      if (sync_cnt == STAGES) base = edge_n;
    end else if (soft_reset) begin
      base = edge_n;
    end
  endtask

  function automatic exp_t expect_now();
    exp_t e;
    e.rn = '0;
    if (sync_cnt >= STAGES) begin
      for (int i = 0; i < OUTPUTS; i++) begin
        e.rn[i] = (edge_n >= base + HOLD + i * DELAY);
      end
    end
    e.rdy = &e.rn;
    return e;
  endfunction

  always @(negedge aclk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks++;
      if (resets_n !== e.rn) begin
        n_fail++;
        $display("FAIL resets_n edge %0d: got %b expected %b", edge_n, resets_n, e.rn);
      end
      n_checks++;
      if (ready !== e.rdy) begin
        n_fail++;
        $display("FAIL ready edge %0d: got %b expected %b", edge_n, ready, e.rdy);
      end
    end
  end

  initial begin
    int soft_left;
    int ar_left;
    int r;
    soft_left = 0;
    ar_left = 0;
    for (int c = 0; c < CYCLES; c++) begin
      @(posedge aclk);
      model_edge();
      #1;
      if (c < 4) begin
        areset = 1'b1;
      end else if (c == 4) begin
        areset = 1'b0;
      end else begin
        r = int'($urandom_range(0, 199));
        if (ar_left > 0) begin
          ar_left--;
          if (ar_left == 0) areset = 1'b0;
        end else if (r < 3) begin
          areset = 1'b1;
          ar_left = int'($urandom_range(1, 3));
        end else if (r < 6) begin
          // short pulse between edges: must clear outputs without a clock
          areset = 1'b1;
          sync_cnt = 0;
          #2;
          areset = 1'b0;
        end
        if (soft_left > 0) begin
          soft_left--;
        end else if ($urandom_range(0, 99) < 4) begin
          soft_left = int'($urandom_range(1, 3));
        end
        soft_reset = (soft_left > 0);
      end
      if (areset) sync_cnt = 0;
      sb_q.push_back(expect_now());
    end
    soft_reset = 1'b0;
    for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge aclk);
    #1;
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
